// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM state encoding and
// default geometry used by the interface, the top and the bench.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_MEM = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    localparam int PC_W_DEF        = 8;
    localparam int FLUSH_DEPTH_DEF = 2;
    localparam int CNT_W_DEF       = 16;
    // Wide enough for the largest supported flush depth (7).
    localparam int FLUSH_CNT_W     = 3;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the branch unit / hazard unit / imem side (master)
// and the fetch PC sequencer (slave).
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             stall_i;
    logic             redirect_i;
    logic [PC_W-1:0]  redirect_pc_i;
    logic             imem_ready_i;
    logic [PC_W-1:0]  pc_o;
    logic             fetch_valid_o;
    logic             flush_o;
    state_e           state_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, imem_ready_i,
        input  pc_o, fetch_valid_o, flush_o, state_o, redirect_cnt_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, imem_ready_i,
        output pc_o, fetch_valid_o, flush_o, state_o, redirect_cnt_o
    );

endinterface : pc_sequencer_if

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences the PC from branch-unit redirects, holds it on
// stalls or imem back-pressure, and squashes younger stages after a redirect.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              FLUSH_DEPTH = FLUSH_DEPTH_DEF,
    parameter int              CNT_W       = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_DEPTH);

    state_e                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   fetch_valid_q;
    logic                   flush_q;
    logic                   redirect_take;

    // NOTE: every signal assigned in always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_take = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                redirect_take = bus.redirect_i;
                if (!bus.stall_i) begin
                    if (bus.imem_ready_i) pc_d    = pc_q + PC_W'(1);
                    else                  state_d = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                redirect_take = bus.redirect_i;
                if (bus.imem_ready_i) begin
                    state_d = ST_FETCH;
                    // Stalled accept: the word is taken but the PC must not move.
                    if (!bus.stall_i) pc_d = pc_q + PC_W'(1);
                end
            end
            ST_FLUSH: begin
                redirect_take = bus.redirect_i;
                flush_cnt_d   = flush_cnt_q - FLUSH_CNT_W'(1);
                if (flush_cnt_q == FLUSH_CNT_W'(1)) state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Redirect outranks stall and imem_ready in every state that accepts it.
        if (redirect_take) begin
            pc_d        = bus.redirect_pc_i;
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            flush_cnt_q   <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_cnt_q   <= flush_cnt_d;
            fetch_valid_q <= (state_d == ST_FETCH) || (state_d == ST_WAIT_MEM);
            flush_q       <= (state_d == ST_FLUSH);
        end
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_take),
        .count (bus.redirect_cnt_o)
    );

    assign bus.pc_o          = pc_q;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.flush_o       = flush_q;
    assign bus.state_o       = state_q;

endmodule : pc_sequencer
